// File: rtl/de1_soc_hex_ctrl_if.sv
// Bus bundle for the HEX sequencer: the Avalon-MM CSR slave signals plus the
// Avalon-MM master signals that reach the hex PIO instances.
// 'slave' is the sequencer's own view; 'master' is the view of whatever sits
// on the other side (CPU bridge and fabric).
interface de1_soc_hex_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest;

    modport slave (
        input  address, chipselect, write_n, writedata, m_waitrequest,
        output readdata, m_address, m_write, m_writedata
    );

    modport master (
        output address, chipselect, write_n, writedata, m_waitrequest,
        input  readdata, m_address, m_write, m_writedata
    );
endinterface

// File: rtl/de1_soc_hex_ctrl.sv
// Six-digit seven-segment sequencer for the DE1-SoC HEX bank.
// Holds a 24-bit value and a per-digit blank mask; every register update
// triggers a sweep that writes one active-low segment pattern per digit to
// consecutive hex PIO instances through an Avalon-MM master.
module de1_soc_hex_ctrl #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned STRIDE     = 16
) (
    input logic               clk,
    input logic               reset_n,
    de1_soc_hex_ctrl_if.slave bus
);

    localparam int unsigned   DW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WRITE
    } state_t;

    // Nibble to active-low segment pattern, bit6..bit0 = g..a.
    function automatic logic [6:0] hex_pattern(input logic [3:0] nib, input logic blank);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return blank ? 7'h7F : pat;
    endfunction

    logic [23:0]   value_q;
    logic          enable_q;
    logic [5:0]    blank_q;
    logic          pending_q;
    logic          pending_d;
    state_t        state_q;
    logic [DW-1:0] digit_q;
    logic [23:0]   shadow_value_q;
    logic [5:0]    shadow_blank_q;
    logic          m_write_q;
    logic [31:0]   m_address_q;
    logic [6:0]    m_pattern_q;

    logic          strobe;
    logic          reg_write;
    logic          start;
    logic          busy;
    logic [DW-1:0] next_digit;
    logic [6:0]    first_pat;
    logic [6:0]    next_pat;
    logic [31:0]   readdata_d;
    logic          unused_wdata;

    // Write decode, sweep start condition and the patterns loaded on the next transfer.
    always_comb begin
        strobe     = bus.chipselect & ~bus.write_n;
        reg_write  = strobe & ((bus.address == 2'd0) | (bus.address == 2'd1));
        start      = (state_q == ST_IDLE) & pending_q & enable_q;
        busy       = (state_q == ST_WRITE);
        // A register write in the start cycle must survive the clear.
        pending_d  = reg_write | (pending_q & ~start);
        next_digit = digit_q + DW'(1);
        first_pat  = hex_pattern(value_q[3:0], blank_q[0]);
        next_pat   = hex_pattern(4'(shadow_value_q >> {next_digit, 2'b00}),
                                 1'(shadow_blank_q >> next_digit));
    end

    // CSR read mux, zero latency.
    always_comb begin
        readdata_d = '0;
        case (bus.address)
            2'd0:    readdata_d = {8'h00, value_q};
            2'd1:    readdata_d = {18'h0, blank_q, 7'h00, enable_q};
            2'd2:    readdata_d = {30'h0, pending_q, busy};
            default: readdata_d = '0;
        endcase
    end

    // Programmer-visible VALUE and CTRL registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q  <= '0;
            enable_q <= 1'b1;
            blank_q  <= '0;
        end else if (strobe) begin
            case (bus.address)
                2'd0: value_q <= bus.writedata[23:0];
                2'd1: begin
                    enable_q <= bus.writedata[0];
                    blank_q  <= bus.writedata[13:8];
                end
                default: ;
            endcase
        end
    end

    // Sweep FSM: snapshots the registers, then issues one master write per digit
    // with outputs registered and held while the fabric stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            pending_q      <= 1'b1;
            digit_q        <= '0;
            shadow_value_q <= '0;
            shadow_blank_q <= '0;
            m_write_q      <= 1'b0;
            m_address_q    <= BASE_ADDR;
            m_pattern_q    <= '0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        shadow_value_q <= value_q;
                        shadow_blank_q <= blank_q;
                        digit_q        <= '0;
                        m_write_q      <= 1'b1;
                        m_address_q    <= BASE_ADDR;
                        m_pattern_q    <= first_pat;
                        state_q        <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!bus.m_waitrequest) begin
                        if (digit_q == LAST_DIGIT) begin
                            digit_q     <= '0;
                            m_write_q   <= 1'b0;
                            m_address_q <= BASE_ADDR;
                            m_pattern_q <= '0;
                            state_q     <= ST_IDLE;
                        end else begin
                            digit_q     <= next_digit;
                            m_address_q <= m_address_q + 32'(STRIDE);
                            m_pattern_q <= next_pat;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.readdata    = readdata_d;
    assign bus.m_write     = m_write_q;
    assign bus.m_address   = m_address_q;
    assign bus.m_writedata = {25'h0, m_pattern_q};
    assign unused_wdata    = &{1'b0, bus.writedata[31:24]};

endmodule

// File: tb/tb_de1_soc_hex_ctrl.sv
// Self-checking bench for de1_soc_hex_ctrl: directed scenarios plus randomized
// value/mask/waitstate sweeps compared against a table-driven display model.
module tb_de1_soc_hex_ctrl;

    localparam logic [31:0] BASE   = 32'h0000_2000;
    localparam int unsigned STRIDE = 16;

    logic clk;
    logic rst_n;

    de1_soc_hex_ctrl_if bus ();

    de1_soc_hex_ctrl #(
        .NUM_DIGITS(6),
        .BASE_ADDR (BASE),
        .STRIDE    (STRIDE)
    ) dut (
        .clk    (clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned fails  = 0;

    logic [31:0] acc_addr [$];
    logic [31:0] acc_data [$];
    int unsigned acc_cyc  [$];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];

    int unsigned cyc = 0;
    int unsigned mw_cycles = 0;
    int unsigned digit2_cycles = 0;
    int unsigned wr_mode = 0;
    int unsigned stall_left = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Bus monitor: records accepted transfers and checks outputs hold during stalls.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_write", 32'(bus.m_write), 32'd1);
                check("hold_addr", bus.m_address, prev_addr);
                check("hold_data", bus.m_writedata, prev_data);
            end
            if (bus.m_write) begin
                mw_cycles++;
                if (bus.m_address == BASE + 32'(2 * STRIDE)) digit2_cycles++;
                if (!bus.m_waitrequest) begin
                    acc_addr.push_back(bus.m_address);
                    acc_data.push_back(bus.m_writedata);
                    acc_cyc.push_back(cyc);
                end
            end
            prev_stall = bus.m_write && bus.m_waitrequest;
            prev_addr  = bus.m_address;
            prev_data  = bus.m_writedata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Fabric stall generator.
    initial begin
        bus.m_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (wr_mode)
                1: bus.m_waitrequest = ($urandom_range(0, 2) == 0);
                2: begin
                    if (bus.m_write && bus.m_address == BASE + 32'(2 * STRIDE) && stall_left > 0) begin
                        bus.m_waitrequest = 1'b1;
                        stall_left--;
                    end else begin
                        bus.m_waitrequest = 1'b0;
                    end
                end
                default: bus.m_waitrequest = 1'b0;
            endcase
        end
    end

    task automatic clear_capture();
        acc_addr.delete();
        acc_data.delete();
        acc_cyc.delete();
        exp_addr.delete();
        exp_data.delete();
        mw_cycles = 0;
        digit2_cycles = 0;
    endtask

    // What the display should receive for one sweep of value/mask.
    task automatic model_sweep(input logic [23:0] value, input logic [5:0] mask);
        for (int i = 0; i < 6; i++) begin
            logic [23:0] v;
            v = value >> (4 * i);
            exp_addr.push_back(BASE + 32'(i * STRIDE));
            exp_data.push_back(mask[i] ? 32'h7F : {25'h0, seg_tbl[v[3:0]]});
        end
    endtask

    task automatic compare_sweeps(input string tag);
        check($sformatf("%s_count", tag), 32'(acc_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < acc_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), acc_addr[i], exp_addr[i]);
            check($sformatf("%s_data%0d", tag, i), acc_data[i], exp_data[i]);
        end
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic csr_check(input logic [1:0] a, input logic [31:0] exp, input string tag);
        @(posedge clk);
        #1;
        bus.address = a;
        @(negedge clk);
        check(tag, bus.readdata, exp);
    endtask

    task automatic wait_done(input string tag);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(posedge clk);
            #1;
            bus.address = 2'd2;
            @(negedge clk);
            done = (bus.readdata[1:0] == 2'b00);
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_addr(input logic [31:0] a, input string tag);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            found = bus.m_write && (bus.m_address == a);
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_write", 32'(bus.m_write), 32'd0);
        check("rst_m_address", bus.m_address, BASE);
        check("rst_m_writedata", bus.m_writedata, 32'd0);
        csr_check(2'd0, 32'h0, "rst_value");
        csr_check(2'd1, 32'h1, "rst_ctrl");
        csr_check(2'd2, 32'h2, "rst_status");
        csr_check(2'd3, 32'h0, "rst_reg3");

        // Initial sweep after reset release.
        clear_capture();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_done("init_done");
        model_sweep(24'h0, 6'h0);
        compare_sweeps("init");
        for (int i = 1; i < acc_cyc.size(); i++)
            check($sformatf("init_b2b%0d", i), 32'(acc_cyc[i] - acc_cyc[0]), 32'(i));
        csr_check(2'd2, 32'h0, "init_status");

        // Register 3 ignores writes and starts nothing.
        clear_capture();
        csr_write(2'd3, 32'hFFFF_FFFF);
        repeat (4) @(posedge clk);
        csr_check(2'd3, 32'h0, "reg3_read");
        csr_check(2'd2, 32'h0, "reg3_status");
        check("reg3_no_sweep", 32'(acc_addr.size()), 32'd0);

        // Hex value with latency check.
        clear_capture();
        csr_write(2'd0, 32'h0012_ABEF);
        @(negedge clk);
        check("lat_n1", 32'(bus.m_write), 32'd0);
        @(negedge clk);
        check("lat_n2", 32'(bus.m_write), 32'd1);
        wait_done("hex_done");
        model_sweep(24'h12ABEF, 6'h0);
        compare_sweeps("hex");
        csr_check(2'd0, 32'h0012_ABEF, "hex_readback");

        // Disabled: writes only set pending; blanking applied when enabled.
        clear_capture();
        csr_write(2'd1, 32'h0000_2100);
        csr_write(2'd0, 32'h0012_3456);
        repeat (6) @(posedge clk);
        check("dis_no_sweep", 32'(acc_addr.size()), 32'd0);
        csr_check(2'd2, 32'h2, "dis_status");
        csr_check(2'd1, 32'h0000_2100, "dis_ctrl");
        csr_write(2'd1, 32'h0000_2101);
        wait_done("blank_done");
        model_sweep(24'h123456, 6'b100001);
        compare_sweeps("blank");

        // Three waitstates on digit 2.
        csr_write(2'd1, 32'h0000_0001);
        wait_done("ws_pre_done");
        clear_capture();
        stall_left = 3;
        wr_mode = 2;
        csr_write(2'd0, 32'h00FE_DCBA);
        wait_done("ws_done");
        wr_mode = 0;
        model_sweep(24'hFEDCBA, 6'h0);
        compare_sweeps("ws");
        check("ws_sweep_cycles", 32'(mw_cycles), 32'd9);
        check("ws_digit2_cycles", 32'(digit2_cycles), 32'd4);

        // Register write during a sweep: snapshot kept, second sweep follows.
        clear_capture();
        csr_write(2'd0, 32'h0);
        wait_addr(BASE + 32'(3 * STRIDE), "mid_wait");
        csr_write(2'd0, 32'h0011_1111);
        wait_done("mid_done");
        model_sweep(24'h000000, 6'h0);
        model_sweep(24'h111111, 6'h0);
        compare_sweeps("mid");

        // Reset during digit 4.
        clear_capture();
        csr_write(2'd0, 32'h0012_3456);
        wait_addr(BASE + 32'(4 * STRIDE), "rst_mid_wait");
        rst_n = 1'b0;
        #1;
        check("rst_mid_m_write", 32'(bus.m_write), 32'd0);
        check("rst_mid_m_address", bus.m_address, BASE);
        check("rst_mid_m_writedata", bus.m_writedata, 32'd0);
        csr_check(2'd2, 32'h2, "rst_mid_status");
        repeat (2) @(posedge clk);
        clear_capture();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_done("rst_mid_done");
        model_sweep(24'h0, 6'h0);
        compare_sweeps("rst_mid");
        csr_check(2'd0, 32'h0, "rst_mid_value");

        // Randomized values, masks and waitstates.
        for (int it = 0; it < 8; it++) begin
            logic [23:0] v;
            logic [5:0]  m;
            v = 24'($urandom);
            m = 6'($urandom_range(0, 63));
            clear_capture();
            wr_mode = 1;
            csr_write(2'd1, {18'h0, m, 8'h00});
            csr_write(2'd0, {8'h00, v});
            csr_write(2'd1, {18'h0, m, 8'h01});
            wait_done($sformatf("rnd%0d_done", it));
            model_sweep(v, m);
            compare_sweeps($sformatf("rnd%0d", it));
        end
        wr_mode = 0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
